// File: rtl/mmu_pkg.sv
// Shared types for the MMU tile sequencer: FSM state codes and the latched tile command.
package mmu_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned CntWidth  = 16;

  // State codes kept as plain constants so older tools can consume them unchanged.
  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StClear   = 3'd1;
  localparam state_t StLoadW   = 3'd2;
  localparam state_t StCompute = 3'd3;
  localparam state_t StDrain   = 3'd4;
  localparam state_t StFinish  = 3'd5;

  // Command fields captured on an accepted START. Field widths follow the package widths, so the
  // sequencer's ADDR_WIDTH / CNT_WIDTH must stay equal to AddrWidth / CntWidth.
  typedef struct packed {
    logic                 skip_wload;
    logic [CntWidth-1:0]  num_vectors;
    logic [AddrWidth-1:0] weight_base;
    logic [AddrWidth-1:0] input_base;
    logic [AddrWidth-1:0] result_base;
  } tile_cfg_t;

endpackage

// File: rtl/mmu_addr_gen.sv
// Registered base+offset address generator; the address holds whenever the enable is low.
module mmu_addr_gen #(
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] offset_i,
  output logic [AddrWidth-1:0] addr_o
);

  logic [AddrWidth-1:0] addr_d, addr_q;

  // Load base+offset (wrapping) when enabled, otherwise keep the last address.
  always_comb begin
    addr_d = addr_q;
    if (en_i) begin
      addr_d = base_i + offset_i;
    end
  end

  // Address register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mmu_sequencer.sv
// Tile sequencer for the systolic MMU: clear, weight load, input streaming and result drain.
// Every output is a flop loaded from the next state, so a state's controls appear during the
// cycle that state is current.
module mmu_sequencer
  import mmu_pkg::*;
#(
  parameter int unsigned LENGTH       = 256,
  parameter int unsigned ADDR_WIDTH   = AddrWidth,
  parameter int unsigned CNT_WIDTH    = CntWidth,
  parameter int unsigned PIPE_LATENCY = 512
) (
  input  logic                  CLK,
  input  logic                  SYNC_RST,
  input  logic                  START,
  input  logic                  SKIP_WLOAD,
  input  logic [CNT_WIDTH-1:0]  NUM_VECTORS,
  input  logic [ADDR_WIDTH-1:0] WEIGHT_BASE,
  input  logic [ADDR_WIDTH-1:0] INPUT_BASE,
  input  logic [ADDR_WIDTH-1:0] RESULT_BASE,
  input  logic                  HOLD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MMU_EN,
  output logic                  MMU_LOAD,
  output logic                  MMU_SYNC_RST,
  output logic                  WBUF_RD_EN,
  output logic [ADDR_WIDTH-1:0] WBUF_ADDR,
  output logic                  IBUF_RD_EN,
  output logic [ADDR_WIDTH-1:0] IBUF_ADDR,
  output logic                  RBUF_WR_EN,
  output logic [ADDR_WIDTH-1:0] RBUF_ADDR
);

  // Step counter must reach PIPE_LATENCY + 2^CNT_WIDTH - 1 (and LENGTH), hence one spare bit.
  localparam int unsigned LatBits = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned LenBits = $clog2(LENGTH + 1);
  localparam int unsigned MaxA    = (CNT_WIDTH > LatBits) ? CNT_WIDTH : LatBits;
  localparam int unsigned CntW    = ((MaxA > LenBits) ? MaxA : LenBits) + 1;

  localparam logic [CntW-1:0] LenX   = CntW'(LENGTH);
  localparam logic [CntW-1:0] LenM1X = CntW'(LENGTH - 1);
  localparam logic [CntW-1:0] LatX   = CntW'(PIPE_LATENCY);
  localparam logic [CntW-1:0] OneX   = CntW'(1);

  state_t          st_d, st_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  tile_cfg_t       cfg_d, cfg_q;
  logic            hold_act;
  logic [CntW-1:0] nv_x, last_e;

  logic busy_d, done_d, mmu_en_d, mmu_load_d, mmu_clr_d, wbuf_en_d, ibuf_en_d, rbuf_en_d;
  logic busy_q, done_q, mmu_en_q, mmu_load_q, mmu_clr_q, wbuf_en_q, ibuf_en_q, rbuf_en_q;
  logic [ADDR_WIDTH-1:0] w_off, i_off, r_off;

  assign nv_x     = CntW'(cfg_q.num_vectors);
  assign last_e   = LatX + nv_x - OneX;
  // HOLD is ignored in IDLE so a START can still be taken.
  assign hold_act = HOLD && (st_q != StIdle);

  // Next-state and step counter; cnt is k in LOAD_W and e in COMPUTE/DRAIN.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    cfg_d = cfg_q;
    if (!hold_act) begin
      case (st_q)
        StIdle: begin
          if (START) begin
            st_d              = StClear;
            cnt_d             = '0;
            cfg_d.skip_wload  = SKIP_WLOAD;
            cfg_d.num_vectors = NUM_VECTORS;
            cfg_d.weight_base = WEIGHT_BASE;
            cfg_d.input_base  = INPUT_BASE;
            cfg_d.result_base = RESULT_BASE;
          end
        end
        StClear: begin
          cnt_d = '0;
          if (!cfg_q.skip_wload) begin
            st_d = StLoadW;
          end else if (nv_x == '0) begin
            st_d = StFinish;
          end else begin
            st_d = StCompute;
          end
        end
        StLoadW: begin
          if (cnt_q == LenX) begin
            cnt_d = '0;
            st_d  = (nv_x == '0) ? StFinish : StCompute;
          end else begin
            cnt_d = cnt_q + OneX;
          end
        end
        StCompute, StDrain: begin
          if (cnt_q == last_e) begin
            cnt_d = '0;
            st_d  = StFinish;
          end else begin
            cnt_d = cnt_q + OneX;
            st_d  = (cnt_d < nv_x) ? StCompute : StDrain;
          end
        end
        StFinish: st_d = StIdle;
        default:  st_d = StIdle;
      endcase
    end
  end

  // Output decode from the upcoming step; a held cycle drops every strobe.
  always_comb begin
    busy_d     = (st_d != StIdle);
    mmu_clr_d  = !hold_act && (st_d == StClear);
    done_d     = !hold_act && (st_d == StFinish);
    wbuf_en_d  = !hold_act && (st_d == StLoadW) && (cnt_d < LenX);
    // Weight data returns one cycle after its read, so shifting starts at k = 1.
    mmu_load_d = !hold_act && (st_d == StLoadW) && (cnt_d != '0);
    ibuf_en_d  = !hold_act && (st_d == StCompute);
    rbuf_en_d  = !hold_act && ((st_d == StCompute) || (st_d == StDrain)) &&
                 (cnt_d >= LatX) && (cnt_d < LatX + nv_x);
    mmu_en_d   = mmu_load_d || (!hold_act && ((st_d == StCompute) || (st_d == StDrain)));
    w_off      = ADDR_WIDTH'(LenM1X - cnt_d);
    i_off      = ADDR_WIDTH'(cnt_d);
    r_off      = ADDR_WIDTH'(cnt_d - LatX);
  end

  // State, counter, command and strobe registers; reset drops any operation in flight.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      cfg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mmu_en_q   <= 1'b0;
      mmu_load_q <= 1'b0;
      mmu_clr_q  <= 1'b0;
      wbuf_en_q  <= 1'b0;
      ibuf_en_q  <= 1'b0;
      rbuf_en_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mmu_en_q   <= mmu_en_d;
      mmu_load_q <= mmu_load_d;
      mmu_clr_q  <= mmu_clr_d;
      wbuf_en_q  <= wbuf_en_d;
      ibuf_en_q  <= ibuf_en_d;
      rbuf_en_q  <= rbuf_en_d;
    end
  end

  mmu_addr_gen #(.AddrWidth(ADDR_WIDTH)) u_wbuf_addr (
    .clk_i    (CLK),
    .rst_i    (SYNC_RST),
    .en_i     (wbuf_en_d),
    .base_i   (cfg_q.weight_base),
    .offset_i (w_off),
    .addr_o   (WBUF_ADDR)
  );

  mmu_addr_gen #(.AddrWidth(ADDR_WIDTH)) u_ibuf_addr (
    .clk_i    (CLK),
    .rst_i    (SYNC_RST),
    .en_i     (ibuf_en_d),
    .base_i   (cfg_q.input_base),
    .offset_i (i_off),
    .addr_o   (IBUF_ADDR)
  );

  mmu_addr_gen #(.AddrWidth(ADDR_WIDTH)) u_rbuf_addr (
    .clk_i    (CLK),
    .rst_i    (SYNC_RST),
    .en_i     (rbuf_en_d),
    .base_i   (cfg_q.result_base),
    .offset_i (r_off),
    .addr_o   (RBUF_ADDR)
  );

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign MMU_EN       = mmu_en_q;
  assign MMU_LOAD     = mmu_load_q;
  assign MMU_SYNC_RST = mmu_clr_q;
  assign WBUF_RD_EN   = wbuf_en_q;
  assign IBUF_RD_EN   = ibuf_en_q;
  assign RBUF_WR_EN   = rbuf_en_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Scoreboard bench for mmu_sequencer: accepted commands expand into expected per-step events,
// and a monitor pops them as the DUT raises each strobe.
module tb_mmu_sequencer;

  localparam int L  = 4;
  localparam int PL = 8;

  localparam int KWb = 0, KIb = 1, KRb = 2, KLd = 3, KEn = 4, KClr = 5, KDone = 6;

  logic        CLK = 1'b0;
  logic        SYNC_RST, START, SKIP_WLOAD, HOLD;
  logic [15:0] NUM_VECTORS, WEIGHT_BASE, INPUT_BASE, RESULT_BASE;
  logic        BUSY, DONE, MMU_EN, MMU_LOAD, MMU_SYNC_RST;
  logic        WBUF_RD_EN, IBUF_RD_EN, RBUF_WR_EN;
  logic [15:0] WBUF_ADDR, IBUF_ADDR, RBUF_ADDR;

  always #5 CLK = ~CLK;

  mmu_sequencer #(
    .LENGTH       (L),
    .ADDR_WIDTH   (16),
    .CNT_WIDTH    (16),
    .PIPE_LATENCY (PL)
  ) dut (
    .CLK          (CLK),
    .SYNC_RST     (SYNC_RST),
    .START        (START),
    .SKIP_WLOAD   (SKIP_WLOAD),
    .NUM_VECTORS  (NUM_VECTORS),
    .WEIGHT_BASE  (WEIGHT_BASE),
    .INPUT_BASE   (INPUT_BASE),
    .RESULT_BASE  (RESULT_BASE),
    .HOLD         (HOLD),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .MMU_EN       (MMU_EN),
    .MMU_LOAD     (MMU_LOAD),
    .MMU_SYNC_RST (MMU_SYNC_RST),
    .WBUF_RD_EN   (WBUF_RD_EN),
    .WBUF_ADDR    (WBUF_ADDR),
    .IBUF_RD_EN   (IBUF_RD_EN),
    .IBUF_ADDR    (IBUF_ADDR),
    .RBUF_WR_EN   (RBUF_WR_EN),
    .RBUF_ADDR    (RBUF_ADDR)
  );

  typedef struct {
    int          kind;
    int          step;
    logic [15:0] addr;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  passes = 0;

  // Reference timeline: steps count non-held cycles after the accepting edge.
  bit  active = 0, held = 0, just_reset = 0, run_mon = 0;
  int  cur_step = 0, cur_final = 0, pend_final = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Expand one accepted command into its expected event list.
  task automatic push_op(bit skip, int nv, logic [15:0] wb, logic [15:0] ib, logic [15:0] rb);
    int c, f;
    evq.push_back('{KClr, 1, 16'h0});
    c = 1;
    if (!skip) begin
      for (int k = 0; k <= L; k++) begin
        if (k < L) evq.push_back('{KWb, 2 + k, wb + 16'(L - 1 - k)});
        if (k >= 1) begin
          evq.push_back('{KLd, 2 + k, 16'h0});
          evq.push_back('{KEn, 2 + k, 16'h0});
        end
      end
      c = 2 + L;
    end
    if (nv > 0) begin
      for (int e = 0; e < PL + nv; e++) begin
        evq.push_back('{KEn, c + 1 + e, 16'h0});
        if (e < nv) evq.push_back('{KIb, c + 1 + e, ib + 16'(e)});
        if (e >= PL) evq.push_back('{KRb, c + 1 + e, rb + 16'(e - PL)});
      end
      f = c + PL + nv + 1;
    end else begin
      f = c + 1;
    end
    evq.push_back('{KDone, f, 16'h0});
    pend_final = f;
  endtask

  task automatic obs(int kind, string name, logic sig, logic [15:0] addr);
    int idx;
    idx = -1;
    if (sig !== 1'b1) return;
    foreach (evq[i]) if (idx < 0 && evq[i].kind == kind) idx = i;
    if (idx < 0) begin
      check({name, " unexpected, step"}, 64'(cur_step), 64'hFFFF_FFFF);
    end else begin
      check({name, " step"}, 64'(cur_step), 64'(evq[idx].step));
      if (kind <= KRb) check({name, " addr"}, 64'(addr), 64'(evq[idx].addr));
      evq.delete(idx);
    end
  endtask

  // Timeline tracker.
  initial forever begin
    @(posedge CLK);
    just_reset = 0;
    if (SYNC_RST) begin
      active = 0; held = 0; cur_step = 0; just_reset = 1;
    end else if (!active) begin
      held = 0;
      if (START) begin
        active = 1; cur_step = 1; cur_final = pend_final;
      end
    end else if (HOLD) begin
      held = 1;
    end else begin
      held = 0;
      cur_step++;
      if (cur_step > cur_final) begin
        active = 0; cur_step = 0;
      end
    end
  end

  // Monitor.
  initial forever begin
    @(posedge CLK);
    #1;
    if (run_mon) begin
      check("BUSY", 64'(BUSY), 64'(active));
      if (just_reset)
        check("post-reset outputs", 64'({BUSY, DONE, MMU_EN, MMU_LOAD, MMU_SYNC_RST, WBUF_RD_EN,
              IBUF_RD_EN, RBUF_WR_EN, WBUF_ADDR, IBUF_ADDR, RBUF_ADDR}), 64'h0);
      if (held)
        check("strobes during hold", 64'({MMU_EN, MMU_LOAD, MMU_SYNC_RST, WBUF_RD_EN, IBUF_RD_EN,
              RBUF_WR_EN, DONE}), 64'h0);
      obs(KWb, "WBUF read", WBUF_RD_EN, WBUF_ADDR);
      obs(KIb, "IBUF read", IBUF_RD_EN, IBUF_ADDR);
      obs(KRb, "RBUF write", RBUF_WR_EN, RBUF_ADDR);
      obs(KLd, "MMU_LOAD", MMU_LOAD, 16'h0);
      obs(KEn, "MMU_EN", MMU_EN, 16'h0);
      obs(KClr, "MMU_SYNC_RST", MMU_SYNC_RST, 16'h0);
      obs(KDone, "DONE", DONE, 16'h0);
    end
  end

  // One-cycle START pulse; expectations are queued only if the sequencer will accept it.
  task automatic issue(bit skip, int nv, logic [15:0] wb, logic [15:0] ib, logic [15:0] rb);
    @(negedge CLK);
    SKIP_WLOAD = skip; NUM_VECTORS = 16'(nv);
    WEIGHT_BASE = wb; INPUT_BASE = ib; RESULT_BASE = rb;
    START = 1'b1;
    if (!active) push_op(skip, nv, wb, ib, rb);
    @(negedge CLK);
    START = 1'b0;
    SKIP_WLOAD = 1'($urandom); NUM_VECTORS = 16'($urandom);
    WEIGHT_BASE = 16'($urandom); INPUT_BASE = 16'($urandom); RESULT_BASE = 16'($urandom);
  endtask

  task automatic finish_op(string name);
    for (int i = 0; i < 500 && active; i++) @(negedge CLK);
    check({name, " completes"}, 64'(active), 64'h0);
    repeat (2) @(negedge CLK);
    check({name, " leftover events"}, 64'(evq.size()), 64'h0);
    evq.delete();
  endtask

  task automatic do_reset(int n);
    @(negedge CLK);
    SYNC_RST = 1'b1; START = 1'b0; HOLD = 1'b0;
    evq.delete();
    repeat (n) @(negedge CLK);
    SYNC_RST = 1'b0;
  endtask

  initial begin
    SYNC_RST = 1'b1; START = 1'b0; HOLD = 1'b0; SKIP_WLOAD = 1'b0;
    NUM_VECTORS = '0; WEIGHT_BASE = '0; INPUT_BASE = '0; RESULT_BASE = '0;
    repeat (3) @(negedge CLK);
    run_mon = 1;
    @(negedge CLK);
    SYNC_RST = 1'b0;

    // Basic tile, weight reuse, and empty tile.
    issue(0, 3, 16'h0010, 16'h0020, 16'h0030);
    finish_op("basic");
    issue(1, 3, 16'h0010, 16'h0020, 16'h0030);
    finish_op("skip_wload");
    issue(0, 0, 16'h0010, 16'h0020, 16'h0030);
    finish_op("nv0");
    issue(1, 0, 16'h0040, 16'h0050, 16'h0060);
    finish_op("skip_nv0");

    // Five held cycles starting right after the e=1 step.
    issue(0, 3, 16'h0010, 16'h0020, 16'h0030);
    repeat (7) @(negedge CLK);
    HOLD = 1'b1;
    repeat (5) @(negedge CLK);
    HOLD = 1'b0;
    finish_op("hold");

    // Reset while the e=6 step is showing, then a fresh command.
    issue(0, 3, 16'h0010, 16'h0020, 16'h0030);
    repeat (11) @(negedge CLK);
    do_reset(1);
    issue(0, 3, 16'h0010, 16'h0020, 16'h0030);
    finish_op("after reset");

    // Extra STARTs while busy, plus result address wrap.
    issue(0, 3, 16'h0100, 16'h0200, 16'hFFFF);
    repeat (3) @(negedge CLK);
    issue(1, 7, 16'h1111, 16'h2222, 16'h3333);
    repeat (6) @(negedge CLK);
    issue(0, 1, 16'h4444, 16'h5555, 16'h6666);
    finish_op("wrap");

    // Random commands with random HOLD and stray STARTs.
    for (int n = 0; n < 30; n++) begin
      issue(1'($urandom), int'($urandom_range(0, 5)), 16'($urandom), 16'($urandom),
            16'($urandom));
      for (int i = 0; i < 300 && active; i++) begin
        HOLD  = ($urandom_range(0, 4) == 0);
        START = ($urandom_range(0, 14) == 0);
        @(negedge CLK);
      end
      START = 1'b0;
      HOLD  = 1'b0;
      finish_op("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
